// File: rtl/frame_sched_pkg.sv
// Shared types and widths for the WS2812B frame scheduler.
// Holds the orientation width, the FSM state enum and a counter-width helper.
package frame_sched_pkg;

  localparam int ORIENT_W = 162;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    LATCH
  } state_e;

  // Counter width for a count of n cycles; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_timer.sv
// Loadable down-counter used for latch, timeout and refresh intervals.
// Load wins over enable; the count parks at zero instead of wrapping.
module sched_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_enable,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/frame_scheduler.sv
// Double-buffered frame sequencer for the LED cube: shadow/active orientation, latch gap, timeout.
// Optional periodic refresh of the active frame is built when REFRESH_TIMER_EN is defined.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int LATCH_CYCLES   = 2400,
  parameter int FRAME_TIMEOUT  = 32768,
  parameter int REFRESH_CYCLES = 400000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  input  logic [ORIENT_W-1:0] orientation_in,
  input  logic                frame_done,
  output logic                start,
  output logic [ORIENT_W-1:0] orientation_out,
  output logic                busy,
  output logic                frame_ack,
  output logic                timeout_err,
  output logic [7:0]          coalesced
);

  localparam int LATCH_W = cnt_width(LATCH_CYCLES);
  localparam int TMO_W   = cnt_width(FRAME_TIMEOUT);

  state_e              r_state;
  state_e              w_next;
  logic [ORIENT_W-1:0] r_shadow;
  logic [ORIENT_W-1:0] r_active;
  logic                r_pending;
  logic                r_timeout_err;
  logic [7:0]          r_coalesced;
  logic                w_commit;
  logic                w_latch_tc;
  logic                w_tmo_tc;
  logic                w_tmo_fire;
  logic                w_refresh_fire;

  assign w_commit   = (r_state == IDLE) && r_pending;
  assign w_tmo_fire = (r_state == SEND) && w_tmo_tc && !frame_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      IDLE:    if (r_pending) w_next = START;
      START:   w_next = SEND;
      SEND:    if (frame_done || w_tmo_tc) w_next = LATCH;
      LATCH:   if (w_latch_tc) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    start     = (r_state == START);
    busy      = (r_state != IDLE);
    frame_ack = (r_state == LATCH) && w_latch_tc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide orientation registers are reset too, so a reset frame core never sees stale data.
      r_shadow      <= '0;
      r_active      <= '0;
      r_pending     <= 1'b0;
      r_coalesced   <= 8'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (load_valid) r_shadow <= orientation_in;
      if (w_commit)   r_active <= r_shadow;
      // A load on the commit cycle keeps pending high so the new data gets its own frame.
      if (load_valid || w_refresh_fire) begin
        r_pending <= 1'b1;
      end else if (w_commit) begin
        r_pending <= 1'b0;
      end
      if (load_valid && r_pending && !w_commit && (r_coalesced != 8'hFF)) begin
        r_coalesced <= r_coalesced + 8'd1;
      end
      if (w_tmo_fire) r_timeout_err <= 1'b1;
    end
  end

  assign orientation_out = r_active;
  assign timeout_err     = r_timeout_err;
  assign coalesced       = r_coalesced;

  // Reloaded throughout SEND so LATCH always starts from a full count.
  sched_timer #(.W(LATCH_W)) u_latch_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == SEND),
    .i_value  (LATCH_W'(LATCH_CYCLES - 1)),
    .i_enable (r_state == LATCH),
    .o_tc     (w_latch_tc)
  );

  // Loaded in START and counted through SEND; terminal count ends the SEND window.
  sched_timer #(.W(TMO_W)) u_timeout_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (r_state == START),
    .i_value  (TMO_W'(FRAME_TIMEOUT - 2)),
    .i_enable (r_state == SEND),
    .o_tc     (w_tmo_tc)
  );

`ifdef REFRESH_TIMER_EN
  localparam int REF_W = cnt_width(REFRESH_CYCLES);

  logic r_refresh_armed;
  logic w_refresh_tc;

  // Refresh only repeats a frame that has actually been shown since reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_armed <= 1'b0;
    end else if (w_commit) begin
      r_refresh_armed <= 1'b1;
    end
  end

  sched_timer #(.W(REF_W)) u_refresh_timer (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_commit),
    .i_value  (REF_W'(REFRESH_CYCLES - 1)),
    .i_enable (r_state == IDLE),
    .o_tc     (w_refresh_tc)
  );

  assign w_refresh_fire = r_refresh_armed && w_refresh_tc && (r_state == IDLE) && !r_pending;
`else
  assign w_refresh_fire = 1'b0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: directed scenarios plus a randomized run
// scored against a load-history model (frame contents and coalesce arithmetic).
module tb_frame_scheduler;
  import frame_sched_pkg::*;

  localparam int LATCH_CYCLES   = 4;
  localparam int FRAME_TIMEOUT  = 16;
  localparam int REFRESH_CYCLES = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_valid;
  logic [ORIENT_W-1:0] orientation_in;
  logic                frame_done;
  logic                start;
  logic [ORIENT_W-1:0] orientation_out;
  logic                busy;
  logic                frame_ack;
  logic                timeout_err;
  logic [7:0]          coalesced;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int                  c;
    logic [ORIENT_W-1:0] v;
  } load_t;

  frame_scheduler #(
    .LATCH_CYCLES   (LATCH_CYCLES),
    .FRAME_TIMEOUT  (FRAME_TIMEOUT),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .load_valid      (load_valid),
    .orientation_in  (orientation_in),
    .frame_done      (frame_done),
    .start           (start),
    .orientation_out (orientation_out),
    .busy            (busy),
    .frame_ack       (frame_ack),
    .timeout_err     (timeout_err),
    .coalesced       (coalesced)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [ORIENT_W-1:0] rand_orient();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[ORIENT_W-1:0];
  endfunction

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; frame_done = 1'b0; orientation_in = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (start === 1'b1) begin seen = 1'b1; break; end
      step();
    end
  endtask

  // Called in START or SEND: ends the frame and returns the frame_ack cycle.
  task automatic finish_frame(output int ack_cyc);
    bit seen;
    seen = 1'b0; ack_cyc = -1;
    step(); step();
    frame_done = 1'b1; step(); frame_done = 1'b0;
    for (int i = 0; i < LATCH_CYCLES + 4; i++) begin
      if (frame_ack === 1'b1) begin seen = 1'b1; ack_cyc = cyc; break; end
      step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL frame_ack_wait got none want pulse within %0d cycles", LATCH_CYCLES + 4); end
    step();
  endtask

  task automatic test_reset();
    int n_start;
    do_reset();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", frame_ack); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    checks++; if (coalesced !== 8'd0) begin errors++; $display("FAIL reset_coalesced got %0d want 0", coalesced); end
    checks++; if (orientation_out !== '0) begin errors++; $display("FAIL reset_orient got %h want 0", orientation_out); end
    n_start = 0;
    for (int i = 0; i < 10; i++) begin
      if (start === 1'b1) n_start++;
      step();
    end
    checks++; if (n_start != 0) begin errors++; $display("FAIL reset_no_start got %0d starts want 0", n_start); end
  endtask

  task automatic test_single_update();
    int l;
    logic [ORIENT_W-1:0] one;
    do_reset();
    repeat (3) step();
    one = '0; one[0] = 1'b1;
    l = cyc;
    orientation_in = one; load_valid = 1'b1; step(); load_valid = 1'b0; orientation_in = '0;
    for (int c = l + 1; c <= l + 15; c++) begin
      if (c == l + 10) frame_done = 1'b1;
      checks++; if (start !== (c == l + 2)) begin errors++; $display("FAIL single_start cyc+%0d got %b want %b", c - l, start, (c == l + 2)); end
      checks++; if (frame_ack !== (c == l + 14)) begin errors++; $display("FAIL single_ack cyc+%0d got %b want %b", c - l, frame_ack, (c == l + 14)); end
      checks++; if (busy !== (c >= l + 2 && c <= l + 14)) begin errors++; $display("FAIL single_busy cyc+%0d got %b want %b", c - l, busy, (c >= l + 2 && c <= l + 14)); end
      if (c >= l + 2) begin
        checks++; if (orientation_out !== one) begin errors++; $display("FAIL single_orient cyc+%0d got %h want %h", c - l, orientation_out, one); end
      end
      step();
      frame_done = 1'b0;
    end
  endtask

  task automatic test_coalescing();
    logic [ORIENT_W-1:0] d, a, b, c;
    bit seen;
    int ack, n_start;
    do_reset();
    d = rand_orient(); a = rand_orient(); b = rand_orient(); c = rand_orient();
    orientation_in = d; load_valid = 1'b1; step(); load_valid = 1'b0;
    wait_start(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL coal_first_start got none want start"); end
    step(); step();
    load_valid = 1'b1;
    orientation_in = a; step();
    orientation_in = b; step();
    orientation_in = c; step();
    load_valid = 1'b0;
    checks++; if (coalesced !== 8'd2) begin errors++; $display("FAIL coal_count got %0d want 2", coalesced); end
    finish_frame(ack);
    wait_start(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL coal_second_start got none want start"); end
    checks++; if (orientation_out !== c) begin errors++; $display("FAIL coal_orient got %h want %h", orientation_out, c); end
    finish_frame(ack);
    n_start = 0;
    for (int i = 0; i < 20; i++) begin
      if (start === 1'b1) n_start++;
      step();
    end
    checks++; if (n_start != 0) begin errors++; $display("FAIL coal_extra_start got %0d want 0", n_start); end
    checks++; if (coalesced !== 8'd2) begin errors++; $display("FAIL coal_count_hold got %0d want 2", coalesced); end
  endtask

  task automatic test_back_to_back();
    logic [ORIENT_W-1:0] a, b;
    bit seen;
    int ack;
    do_reset();
    a = rand_orient(); b = rand_orient();
    orientation_in = a; load_valid = 1'b1; step();
    orientation_in = b; step();
    load_valid = 1'b0;
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL b2b_first_start got %b want 1", start); end
    checks++; if (orientation_out !== a) begin errors++; $display("FAIL b2b_first_orient got %h want %h", orientation_out, a); end
    finish_frame(ack);
    wait_start(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL b2b_second_start got none want start"); end
    checks++; if (orientation_out !== b) begin errors++; $display("FAIL b2b_second_orient got %h want %h", orientation_out, b); end
    checks++; if (coalesced !== 8'd0) begin errors++; $display("FAIL b2b_coalesced got %0d want 0", coalesced); end
    finish_frame(ack);
  endtask

  task automatic test_timeout();
    bit seen;
    int s;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pre got %b want 0", timeout_err); end
    orientation_in = rand_orient(); load_valid = 1'b1; step(); load_valid = 1'b0;
    wait_start(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL tmo_start got none want start"); end
    s = cyc;
    for (int c = s; c <= s + 20; c++) begin
      checks++; if (timeout_err !== (c >= s + FRAME_TIMEOUT)) begin errors++; $display("FAIL tmo_err cyc+%0d got %b want %b", c - s, timeout_err, (c >= s + FRAME_TIMEOUT)); end
      checks++; if (frame_ack !== (c == s + FRAME_TIMEOUT + LATCH_CYCLES - 1)) begin errors++; $display("FAIL tmo_ack cyc+%0d got %b want %b", c - s, frame_ack, (c == s + FRAME_TIMEOUT + LATCH_CYCLES - 1)); end
      checks++; if (busy !== (c <= s + FRAME_TIMEOUT + LATCH_CYCLES - 1)) begin errors++; $display("FAIL tmo_busy cyc+%0d got %b want %b", c - s, busy, (c <= s + FRAME_TIMEOUT + LATCH_CYCLES - 1)); end
      step();
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [ORIENT_W-1:0] x;
    bit seen;
    int n_start, n_busy, ack;
    orientation_in = rand_orient(); load_valid = 1'b1; step(); load_valid = 1'b0;
    wait_start(6, seen);
    step();
    load_valid = 1'b1;
    orientation_in = rand_orient(); step();
    orientation_in = rand_orient(); step();
    load_valid = 1'b0;
    checks++; if (coalesced !== 8'd1) begin errors++; $display("FAIL mfr_pre_coalesced got %0d want 1", coalesced); end
    step();
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL mfr_start got %b want 0", start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mfr_busy got %b want 0", busy); end
    checks++; if (frame_ack !== 1'b0) begin errors++; $display("FAIL mfr_ack got %b want 0", frame_ack); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL mfr_timeout_err got %b want 0", timeout_err); end
    checks++; if (coalesced !== 8'd0) begin errors++; $display("FAIL mfr_coalesced got %0d want 0", coalesced); end
    checks++; if (orientation_out !== '0) begin errors++; $display("FAIL mfr_orient got %h want 0", orientation_out); end
    n_start = 0; n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      frame_done = (i == 5);
      if (start === 1'b1) n_start++;
      if (busy === 1'b1) n_busy++;
      step();
    end
    frame_done = 1'b0;
    checks++; if (n_start != 0) begin errors++; $display("FAIL mfr_no_start got %0d want 0", n_start); end
    checks++; if (n_busy != 0) begin errors++; $display("FAIL mfr_no_busy got %0d busy cycles want 0", n_busy); end
    x = rand_orient();
    orientation_in = x; load_valid = 1'b1; step(); load_valid = 1'b0;
    wait_start(6, seen);
    checks++; if (!seen) begin errors++; $display("FAIL mfr_restart got none want start"); end
    checks++; if (orientation_out !== x) begin errors++; $display("FAIL mfr_restart_orient got %h want %h", orientation_out, x); end
    finish_frame(ack);
  endtask

  task automatic test_refresh();
    logic [ORIENT_W-1:0] v;
    bit seen;
    int ack, first;
    logic [ORIENT_W-1:0] first_orient;
    do_reset();
    v = rand_orient();
    orientation_in = v; load_valid = 1'b1; step(); load_valid = 1'b0;
    wait_start(6, seen);
    finish_frame(ack);
    first = -1; first_orient = '0;
    for (int i = 0; i < 50; i++) begin
      if (start === 1'b1 && first < 0) begin first = cyc; first_orient = orientation_out; end
      step();
    end
`ifdef REFRESH_TIMER_EN
    checks++; if (first != ack + REFRESH_CYCLES + 2) begin errors++; $display("FAIL refresh_cycle got ack+%0d want ack+%0d", first - ack, REFRESH_CYCLES + 2); end
    checks++; if (first_orient !== v) begin errors++; $display("FAIL refresh_orient got %h want %h", first_orient, v); end
    checks++; if (coalesced !== 8'd0) begin errors++; $display("FAIL refresh_coalesced got %0d want 0", coalesced); end
`else
    checks++; if (first != -1) begin errors++; $display("FAIL refresh_none got start at ack+%0d want no start", first - ack); end
`endif
  endtask

  task automatic test_random();
    load_t q[$];
    load_t e;
    int loads, starts, acks, exp_coal;
    bit prev_start;
    logic [ORIENT_W-1:0] exp_v;
    do_reset();
    loads = 0; starts = 0; acks = 0; prev_start = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      if (start === 1'b1) begin
        starts++;
        // A frame shows the newest load issued at least two cycles before its start.
        exp_v = '0;
        for (int k = q.size() - 1; k >= 0; k--) begin
          if (q[k].c <= cyc - 2) begin exp_v = q[k].v; break; end
        end
        checks++; if (orientation_out !== exp_v) begin errors++; $display("FAIL rand_orient cyc %0d got %h want %h", cyc, orientation_out, exp_v); end
        checks++; if (prev_start) begin errors++; $display("FAIL rand_start_pulse cyc %0d got 2-cycle start want 1-cycle", cyc); end
      end
      if (frame_ack === 1'b1) acks++;
      prev_start = (start === 1'b1);
      load_valid = (i < 800) && ($urandom_range(0, 5) == 0);
      if (load_valid) begin
        e.c = cyc; e.v = rand_orient();
        orientation_in = e.v;
        q.push_back(e);
        loads++;
      end
      frame_done = ($urandom_range(0, 7) == 0);
      step();
    end
    load_valid = 1'b0; frame_done = 1'b0;
    exp_coal = (loads - starts > 255) ? 255 : loads - starts;
`ifdef REFRESH_TIMER_EN
    checks++; if (starts < loads - int'(coalesced)) begin errors++; $display("FAIL rand_starts got %0d want at least %0d", starts, loads - int'(coalesced)); end
`else
    checks++; if (int'(coalesced) != exp_coal) begin errors++; $display("FAIL rand_coalesced got %0d want %0d", coalesced, exp_coal); end
    checks++; if (acks != starts) begin errors++; $display("FAIL rand_acks got %0d want %0d", acks, starts); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_drained_busy got %b want 0", busy); end
`endif
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; frame_done = 1'b0; orientation_in = '0;
    test_reset();
    test_single_update();
    test_coalescing();
    test_back_to_back();
    test_timeout();
    test_mid_frame_reset();
    test_refresh();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
